// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter:
// FSM states, port ids and the address check.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Legal iff word aligned and word index < depth.
  function automatic logic addr_ok(
    input logic [31:0] a,
    input int unsigned depth
  );
    return (a[1:0] == 2'b00) &&
           ({2'b00, a[31:2]} < depth);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker.
// req[1:0], prio (tie winner) -> one-hot gnt.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = prio ? 2'b10 : 2'b01;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for
// the data memory: IDLE grant, ACCESS strobe, RESP ack.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] Adress,
  output logic [31:0] WriteD,
  input  logic [31:0] Rdata
);

  localparam int AW = $clog2(DEPTH);

  state_t      state;
  state_t      nxt;
  logic        prio;
  logic        gid;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  gnt;
  logic        legal;

  rr_arb2 u_arb (
    .req  ({p1_req, p0_req}),
    .prio (prio),
    .gnt  (gnt)
  );

  assign legal = addr_ok(addr_q, DEPTH);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (|gnt) nxt = ACCESS;
      ACCESS:  nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prio     <= PORT_CPU;
      gid      <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && |gnt) begin
        gid     <= gnt[1];
        we_q    <= gnt[1] ? p1_we    : p0_we;
        addr_q  <= gnt[1] ? p1_addr  : p0_addr;
        wdata_q <= gnt[1] ? p1_wdata : p0_wdata;
      end
      if (state == ACCESS) begin
        rsp_err  <= !legal;
        rsp_data <= (legal && !we_q) ? Rdata : '0;
      end
      if (state == RESP)
        prio <= ~gid;
    end
  end

  always_comb begin
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    Adress   = '0;
    WriteD   = '0;
    p0_ack   = 1'b0;
    p0_err   = 1'b0;
    p0_rdata = '0;
    p1_ack   = 1'b0;
    p1_err   = 1'b0;
    p1_rdata = '0;
    unique case (1'b1)
      (state == ACCESS && legal): begin
        Adress   = 32'(addr_q[AW+1:2]);
        MemWrite = we_q;
        MemRead  = !we_q;
        WriteD   = we_q ? wdata_q : '0;
      end
      (state == RESP && gid == PORT_CPU): begin
        p0_ack   = 1'b1;
        p0_err   = rsp_err;
        p0_rdata = rsp_data;
      end
      (state == RESP && gid == PORT_DBG): begin
        p1_ack   = 1'b1;
        p1_err   = rsp_err;
        p1_rdata = rsp_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a
// small behavioural data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_ack, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_ack, p1_err;
  logic [31:0] p1_rdata;
  logic        MemWrite, MemRead;
  logic [31:0] Adress, WriteD, Rdata;

  logic [31:0] mem [32];

  int vec  = 0;
  int miss = 0;

  dmem_arbiter #(.DEPTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_ack   (p0_ack),
    .p0_err   (p0_err),
    .p0_rdata (p0_rdata),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_ack   (p1_ack),
    .p1_err   (p1_err),
    .p1_rdata (p1_rdata),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .Adress   (Adress),
    .WriteD   (WriteD),
    .Rdata    (Rdata)
  );

  always #5 clk = ~clk;

  assign Rdata = mem[Adress[4:0]];

  always @(posedge clk) begin
    if (reset) begin
      mem[0] <= 32'hCAFE_F00D;
      mem[2] <= 32'hDEAD_BEEF;
    end else if (MemWrite) begin
      mem[Adress[4:0]] <= WriteD;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    p0_req   = 1'b0;
    p0_we    = 1'b0;
    p0_addr  = '0;
    p0_wdata = '0;
    p1_req   = 1'b0;
    p1_we    = 1'b0;
    p1_addr  = '0;
    p1_wdata = '0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_memw",  32'(MemWrite), 0);
    chk("rst_memr",  32'(MemRead),  0);
    chk("rst_adr",   Adress,        0);
    chk("rst_wd",    WriteD,        0);
    chk("rst_ack0",  32'(p0_ack),   0);
    chk("rst_ack1",  32'(p1_ack),   0);
    chk("rst_rd0",   p0_rdata,      0);

    // single load p0 @0x8
    p0_req  = 1'b1;
    p0_we   = 1'b0;
    p0_addr = 32'h0000_0008;
    tick();
    chk("ld_memr",  32'(MemRead),  1);
    chk("ld_memw",  32'(MemWrite), 0);
    chk("ld_adr",   Adress,        2);
    chk("ld_ack_e", 32'(p0_ack),   0);
    tick();
    chk("ld_ack",   32'(p0_ack),   1);
    chk("ld_rd",    p0_rdata,      32'hDEAD_BEEF);
    chk("ld_err",   32'(p0_err),   0);
    chk("ld_ack1",  32'(p1_ack),   0);
    chk("ld_memr2", 32'(MemRead),  0);
    p0_req = 1'b0;
    tick();
    chk("ld_ack_l", 32'(p0_ack),   0);

    // p1 store 0x12345678 @0x7C
    p1_req   = 1'b1;
    p1_we    = 1'b1;
    p1_addr  = 32'h0000_007C;
    p1_wdata = 32'h1234_5678;
    tick();
    chk("st_memw",  32'(MemWrite), 1);
    chk("st_memr",  32'(MemRead),  0);
    chk("st_adr",   Adress,        31);
    chk("st_wd",    WriteD,        32'h1234_5678);
    tick();
    chk("st_memw2", 32'(MemWrite), 0);
    chk("st_ack",   32'(p1_ack),   1);
    chk("st_rd",    p1_rdata,      0);
    chk("st_err",   32'(p1_err),   0);
    chk("st_ack0",  32'(p0_ack),   0);
    p1_req = 1'b0;
    tick();

    // p1 load back @0x7C
    p1_req = 1'b1;
    p1_we  = 1'b0;
    tick();
    chk("lb_memr",  32'(MemRead),  1);
    chk("lb_adr",   Adress,        31);
    tick();
    chk("lb_ack",   32'(p1_ack),   1);
    chk("lb_rd",    p1_rdata,      32'h1234_5678);
    p1_req = 1'b0;
    tick();

    // misaligned p0 load @0x6
    p0_req  = 1'b1;
    p0_we   = 1'b0;
    p0_addr = 32'h0000_0006;
    tick();
    chk("mis_memr", 32'(MemRead),  0);
    chk("mis_memw", 32'(MemWrite), 0);
    chk("mis_adr",  Adress,        0);
    tick();
    chk("mis_ack",  32'(p0_ack),   1);
    chk("mis_err",  32'(p0_err),   1);
    chk("mis_rd",   p0_rdata,      0);
    p0_req = 1'b0;
    tick();

    // out of range p0 load @0x80
    p0_req  = 1'b1;
    p0_addr = 32'h0000_0080;
    tick();
    chk("oor_memr", 32'(MemRead),  0);
    chk("oor_memw", 32'(MemWrite), 0);
    tick();
    chk("oor_ack",  32'(p0_ack),   1);
    chk("oor_err",  32'(p0_err),   1);
    chk("oor_rd",   p0_rdata,      0);
    p0_req = 1'b0;
    tick();

    // reset during ACCESS (prio is now port 1)
    p0_req  = 1'b1;
    p0_addr = 32'h0000_0008;
    tick();
    chk("rx_memr",  32'(MemRead),  1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rx_ack0",  32'(p0_ack),   0);
    chk("rx_memr2", 32'(MemRead),  0);
    chk("rx_adr",   Adress,        0);

    // tie after reset: p0 first, then alternate
    p1_req  = 1'b1;
    p1_we   = 1'b0;
    p1_addr = 32'h0000_007C;
    tick();
    chk("tie_adr",  Adress,        2);
    tick();
    chk("tie_ack0", 32'(p0_ack),   1);
    chk("tie_ack1", 32'(p1_ack),   0);
    chk("tie_rd0",  p0_rdata,      32'hDEAD_BEEF);
    tick();
    chk("tie_idle", 32'(p0_ack | p1_ack), 0);

    for (int i = 0; i < 4; i++) begin
      logic p;
      p = (i % 2 == 0);
      tick();
      chk("cnt_adr", Adress, p ? 32'd31 : 32'd2);
      tick();
      chk("cnt_ack0", 32'(p0_ack), p ? 0 : 1);
      chk("cnt_ack1", 32'(p1_ack), p ? 1 : 0);
      chk("cnt_rd",   p ? p1_rdata : p0_rdata,
          p ? 32'h1234_5678 : 32'hDEAD_BEEF);
      tick();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    chk("end_memr", 32'(MemRead), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
